rtc_bus_responder: RTL and testbench
====================================

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset, listed first: clk input 1 (rising-edge system clock), reset_n input 1 (asynchronous, active-low reset).
REQ-002 The module SHALL provide port cs_n, input, 1 bit: chip select, active low.
REQ-003 The module SHALL provide port as, input, 1 bit: address strobe, active high; the address is latched on its falling edge.
REQ-004 The module SHALL provide port rd_n, input, 1 bit: read strobe, active low.
REQ-005 The module SHALL provide port wr_n, input, 1 bit: write strobe, active low.
REQ-006 The module SHALL provide port ad_in, input, 8 bits: multiplexed address/data value sampled from the AD bus.
REQ-007 The module SHALL provide port ad_out, output, 8 bits: read data to be driven onto the AD bus.
REQ-008 The module SHALL provide port ad_oe, output, 1 bit: AD bus drive enable toward the external tri-state pad.

Function
REQ-009 All of cs_n, as, rd_n, wr_n and ad_in SHALL pass through a 2-flop synchronizer; edge detection SHALL use only synchronized values.
REQ-010 The register file SHALL be 16 x 8 bits at addresses 0x00-0x0F.
REQ-011 Addresses with bits [7:4] != 0 SHALL be out of range: writes are ignored and reads return 0xFF.
REQ-012 The FSM states SHALL be IDLE, ADDR, READ, WRITE and ERR.
REQ-013 A synchronized falling edge of as while cs_n is low SHALL latch ad_in into the address register, from any state except ERR, and SHALL move the FSM to ADDR.
REQ-014 In ADDR, a synchronized falling edge of rd_n with wr_n high SHALL move the FSM to READ.
REQ-015 In READ, ad_out SHALL equal reg[addr] and ad_oe SHALL be 1, registered, 3 clk cycles after rd_n falls.
REQ-016 ad_out SHALL be held stable for the whole READ state.
REQ-017 READ SHALL exit to ADDR with ad_oe = 0 in the cycle after synchronized rd_n is high or synchronized cs_n is high.
REQ-018 In ADDR, a synchronized falling edge of wr_n with rd_n high SHALL move the FSM to WRITE.
REQ-019 In WRITE, the data register SHALL capture synchronized ad_in every cycle.
REQ-020 On the synchronized rising edge of wr_n in WRITE, the captured byte SHALL be committed to reg[addr] and the FSM SHALL return to ADDR.
REQ-021 If cs_n rises during WRITE, the write SHALL be aborted with no commit and the FSM SHALL go to IDLE.
REQ-022 Synchronized rd_n and wr_n both low SHALL force ERR with ad_oe = 0; ERR SHALL exit to IDLE only once both strobes are high.
REQ-023 A synchronized high cs_n SHALL return the FSM to IDLE from any state, with ad_oe = 0 in the next cycle.
REQ-024 The address register SHALL persist across transactions until the next as falling edge.
REQ-025 rd_n or wr_n edges in IDLE SHALL be ignored.
REQ-026 ad_oe SHALL never be 1 outside READ.

Reset
REQ-027 reset_n low SHALL immediately force ad_oe = 0, ad_out = 0x00 and FSM = IDLE, independent of clk.
REQ-028 reset_n low SHALL clear the address register to 0x00, all 16 registers to 0x00 and all synchronizer flops to their idle levels (cs_n, rd_n, wr_n = 1; as = 0).
REQ-029 A reset asserted mid-READ SHALL release the bus asynchronously.
REQ-030 A reset asserted mid-WRITE SHALL discard the pending byte.

Configuration
REQ-031 Macro RTC_RESP_TIMEKEEP_EN defined SHALL add input tick_1hz (1 bit, a single-cycle pulse, synchronous to clk).
REQ-032 With the macro defined, each tick SHALL increment reg0 as BCD seconds (0x59 -> 0x00 with carry) into reg1 as BCD minutes (0x59 -> 0x00 with carry), and into reg2 as BCD hours (0x23 -> 0x00).
REQ-033 With the macro defined, a write commit and a tick affecting the same register in the same cycle SHALL resolve with the write winning and no carry generated from it.
REQ-034 Without the macro, tick_1hz SHALL be absent and registers SHALL change only by writes or reset.

Structure
REQ-035 Package rtc_resp_pkg SHALL hold the FSM state typedef, NUM_REGS = 16, ADDR_W = 4, RD_OOR_VALUE = 0xFF, and the SEC, MIN and HOUR address constants 0x00, 0x01 and 0x02.
REQ-036 Sub-module rtc_sync2 (a 2-flop synchronizer with a parameterized width and reset value) SHALL be instantiated once per synchronized input group.

Verification
REQ-037 Bench SHALL cover write then read: as latches 0x05, wr_n pulses with ad_in = 0x3C, then a read of 0x05 -> ad_oe = 1 with ad_out = 0x3C, asserted 3 cycles after rd_n falls.
REQ-038 Bench SHALL cover out of range: as latches 0x1A, write 0x55, then read 0x1A -> ad_out = 0xFF, and all 16 registers unchanged.
REQ-039 Bench SHALL cover a protocol error: rd_n and wr_n driven low together -> ad_oe stays 0, the FSM is in ERR, and no register is modified.
REQ-040 Bench SHALL cover an aborted write: cs_n rises while wr_n is low -> reg[addr] is unchanged and the FSM is in IDLE.
REQ-041 Bench SHALL cover reset mid-read: reset_n driven low during READ -> ad_oe = 0 before the next clk edge, and a subsequent read of 0x05 returns 0x00.
REQ-042 With RTC_RESP_TIMEKEEP_EN defined, bench SHALL cover the rollover: preload reg2..reg0 = 0x23, 0x59, 0x59, pulse tick_1hz -> reg2..reg0 = 0x00, 0x00, 0x00.

Source files
------------

// File: rtl/rtc_resp_pkg.sv
// Shared types and constants for the RTC bus responder: FSM states, register
// file geometry, out-of-range read value and the timekeeping BCD helper.
package rtc_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_ERR
    } state_t;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    localparam logic [7:0] RD_OOR_VALUE = 8'hFF;

    localparam logic [ADDR_W-1:0] SEC_ADDR  = 4'h0;
    localparam logic [ADDR_W-1:0] MIN_ADDR  = 4'h1;
    localparam logic [ADDR_W-1:0] HOUR_ADDR = 4'h2;

    // BCD increment that wraps to 0x00 once max_val has been reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
        if (val == max_val) begin
            return 8'h00;
        end else if (val[3:0] == 4'h9) begin
            return {val[7:4] + 4'h1, 4'h0};
        end else begin
            return val + 8'h01;
        end
    endfunction

endpackage

// File: rtl/rtc_sync2.sv
// Two-flop synchronizer for a group of asynchronous inputs, with a
// parameterized width and a reset value matching the group's idle levels.
module rtc_sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Multiplexed AD-bus responder for a 16 x 8 register file. Defining
// RTC_RESP_TIMEKEEP_EN adds tick_1hz and BCD seconds/minutes/hours in reg0..reg2.
//
// state    | meaning
// ST_IDLE  | not selected, or transaction aborted; strobes ignored
// ST_ADDR  | address latched, waiting for a read or write strobe
// ST_READ  | driving reg[addr] (or 0xFF out of range) with ad_oe high
// ST_WRITE | capturing ad_in each cycle, commit on wr_n rising
// ST_ERR   | rd_n and wr_n seen low together; left only once both are high
module rtc_bus_responder
    import rtc_resp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       as,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] ad_in,
`ifdef RTC_RESP_TIMEKEEP_EN
    input  logic       tick_1hz,
`endif
    output logic [7:0] ad_out,
    output logic       ad_oe
);

    localparam logic [3:0] CTL_IDLE = 4'b1011;  // {cs_n, as, rd_n, wr_n}

    logic [3:0] ctl_s;
    logic [7:0] ad_in_s;
    logic       cs_n_s, as_s, rd_n_s, wr_n_s;

    rtc_sync2 #(.W(4), .RST_VAL(CTL_IDLE)) u_sync_ctl (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({cs_n, as, rd_n, wr_n}),
        .q       (ctl_s)
    );

    rtc_sync2 #(.W(8), .RST_VAL(8'h00)) u_sync_ad (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ad_in),
        .q       (ad_in_s)
    );

    assign {cs_n_s, as_s, rd_n_s, wr_n_s} = ctl_s;

    state_t            state_q, state_d;
    logic [3:0]        ctl_prev_q, ctl_prev_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic              wr_commit, wr_en, addr_in_range;
    logic [ADDR_W-1:0] wr_idx;
    logic [7:0]        rd_value;
    logic              as_fall, rd_fall, wr_fall, wr_rise;

    assign as_fall = ctl_prev_q[2] & ~as_s;
    assign rd_fall = ctl_prev_q[1] & ~rd_n_s;
    assign wr_fall = ctl_prev_q[0] & ~wr_n_s;
    assign wr_rise = ~ctl_prev_q[0] & wr_n_s;

    assign addr_in_range = (addr_q[7:ADDR_W] == '0);
    assign wr_idx        = addr_q[ADDR_W-1:0];
    assign wr_en         = wr_commit & addr_in_range;
    assign rd_value      = addr_in_range ? regs_q[wr_idx] : RD_OOR_VALUE;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ad_out_d   = ad_out_q;
        ctl_prev_d = ctl_s;
        wr_commit  = 1'b0;
        if (state_q == ST_ERR) begin
            if (rd_n_s && wr_n_s) state_d = ST_IDLE;
        end else if (cs_n_s) begin
            state_d = ST_IDLE;
        end else if (!rd_n_s && !wr_n_s) begin
            state_d = ST_ERR;
        end else if (as_fall) begin
            addr_d  = ad_in_s;
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (rd_fall && wr_n_s) begin
                        state_d  = ST_READ;
                        ad_out_d = rd_value;
                    end else if (wr_fall && rd_n_s) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (rd_n_s) state_d = ST_ADDR;
                end
                ST_WRITE: begin
                    data_d = ad_in_s;
                    if (wr_rise) begin
                        wr_commit = 1'b1;
                        state_d   = ST_ADDR;
                    end
                end
                default: ;
            endcase
        end
        ad_oe_d = (state_d == ST_READ);
    end

`ifdef RTC_RESP_TIMEKEEP_EN
    logic sec_carry, min_carry;
`endif

    // A write commit overrides the tick on its register and suppresses that register's carry.
    always_comb begin
        regs_d = regs_q;
`ifdef RTC_RESP_TIMEKEEP_EN
        sec_carry = 1'b0;
        min_carry = 1'b0;
        if (tick_1hz) begin
            regs_d[SEC_ADDR] = bcd_inc(regs_q[SEC_ADDR], 8'h59);
            sec_carry = (regs_q[SEC_ADDR] == 8'h59) && !(wr_en && wr_idx == SEC_ADDR);
            if (sec_carry) begin
                regs_d[MIN_ADDR] = bcd_inc(regs_q[MIN_ADDR], 8'h59);
                min_carry = (regs_q[MIN_ADDR] == 8'h59) && !(wr_en && wr_idx == MIN_ADDR);
            end
            if (min_carry) regs_d[HOUR_ADDR] = bcd_inc(regs_q[HOUR_ADDR], 8'h23);
        end
`endif
        if (wr_en) regs_d[wr_idx] = data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ctl_prev_q <= CTL_IDLE;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            ctl_prev_q <= ctl_prev_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            regs_q     <= regs_d;
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: directed protocol cases plus
// randomized transactions against a register-array model of the bus.
module tb_rtc_bus_responder;
    import rtc_resp_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       as = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe;
`ifdef RTC_RESP_TIMEKEEP_EN
    logic       tick_1hz = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl_regs [16];
    logic [7:0] mdl_addr;

    always #5 clk = ~clk;

    rtc_bus_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cs_n     (cs_n),
        .as       (as),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .ad_in    (ad_in),
`ifdef RTC_RESP_TIMEKEEP_EN
        .tick_1hz (tick_1hz),
`endif
        .ad_out   (ad_out),
        .ad_oe    (ad_oe)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] mdl_read();
        return (mdl_addr < 8'd16) ? mdl_regs[mdl_addr[3:0]] : 8'hFF;
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) check(tag, dut.regs_q[i], mdl_regs[i]);
    endtask

    task automatic set_addr(input logic [7:0] a);
        cs_n  = 1'b0;
        ad_in = a;
        as    = 1'b1;
        cyc(3);
        as = 1'b0;
        cyc(4);
        mdl_addr = a;
    endtask

    task automatic do_write(input logic [7:0] d);
        ad_in = d;
        wr_n  = 1'b0;
        cyc(5);
        wr_n = 1'b1;
        cyc(4);
        if (mdl_addr < 8'd16) mdl_regs[mdl_addr[3:0]] = d;
    endtask

    // rd_n falls right after a negedge; ad_oe must rise on the third clk edge.
    task automatic do_read(input string tag);
        logic [7:0] exp;
        exp  = mdl_read();
        rd_n = 1'b0;
        cyc(2);
        check({tag, "_oe_early"}, {7'd0, ad_oe}, 8'h00);
        cyc(1);
        check({tag, "_oe"}, {7'd0, ad_oe}, 8'h01);
        check({tag, "_data"}, ad_out, exp);
        ad_in = ~ad_in;
        cyc(3);
        check({tag, "_hold"}, ad_out, exp);
        rd_n = 1'b1;
        cyc(2);
        check({tag, "_oe_tail"}, {7'd0, ad_oe}, 8'h01);
        cyc(1);
        check({tag, "_oe_off"}, {7'd0, ad_oe}, 8'h00);
        check({tag, "_st_addr"}, 8'(dut.state_q), 8'(ST_ADDR));
    endtask

`ifdef RTC_RESP_TIMEKEEP_EN
    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] tens, ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic mdl_tick();
        int t;
        t = bcd2int(mdl_regs[2]) * 3600 + bcd2int(mdl_regs[1]) * 60 + bcd2int(mdl_regs[0]);
        t = (t + 1) % 86400;
        mdl_regs[2] = int2bcd(t / 3600);
        mdl_regs[1] = int2bcd((t / 60) % 60);
        mdl_regs[0] = int2bcd(t % 60);
    endtask

    task automatic tick_case(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_addr(8'h00); do_write(s);
        set_addr(8'h01); do_write(m);
        set_addr(8'h02); do_write(h);
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        mdl_tick();
        cyc(1);
        for (int i = 0; i < 3; i++) check("tick_reg", dut.regs_q[i], mdl_regs[i]);
    endtask
`endif

    initial begin
        logic [7:0] a;
        for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
        mdl_addr = 8'h00;

        cyc(3);
        check("rst_oe", {7'd0, ad_oe}, 8'h00);
        check("rst_out", ad_out, 8'h00);
        check("rst_state", 8'(dut.state_q), 8'(ST_IDLE));
        reset_n = 1'b1;
        cyc(2);

        set_addr(8'h05);
        do_write(8'h3C);
        check("wr_mdl_3c", mdl_regs[5], 8'h3C);
        do_read("rd_05");

        set_addr(8'h1A);
        do_write(8'h55);
        do_read("rd_oor");
        check_all_regs("oor_regs");

        set_addr(8'h05);
        rd_n = 1'b0;
        wr_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            check("err_oe", {7'd0, ad_oe}, 8'h00);
        end
        check("err_state", 8'(dut.state_q), 8'(ST_ERR));
        check_all_regs("err_regs");
        rd_n = 1'b1;
        wr_n = 1'b1;
        cyc(4);
        check("err_exit", 8'(dut.state_q), 8'(ST_IDLE));

        set_addr(8'h07);
        ad_in = 8'hA5;
        wr_n  = 1'b0;
        cyc(5);
        check("abort_in_wr", 8'(dut.state_q), 8'(ST_WRITE));
        cs_n = 1'b1;
        cyc(4);
        check("abort_state", 8'(dut.state_q), 8'(ST_IDLE));
        wr_n = 1'b1;
        cyc(4);
        check("abort_reg7", dut.regs_q[7], mdl_regs[7]);
        check("abort_idle", 8'(dut.state_q), 8'(ST_IDLE));

        set_addr(8'h05);
        rd_n = 1'b0;
        cyc(4);
        check("mid_rd_oe", {7'd0, ad_oe}, 8'h01);
        check("mid_rd_data", ad_out, 8'h3C);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_rd_oe", {7'd0, ad_oe}, 8'h00);
        check("rst_rd_out", ad_out, 8'h00);
        check("rst_rd_state", 8'(dut.state_q), 8'(ST_IDLE));
        for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
        mdl_addr = 8'h00;
        rd_n = 1'b1;
        cs_n = 1'b1;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        check_all_regs("rst_regs");
        set_addr(8'h05);
        do_read("rd_post_rst");

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(16, 255));
            else a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                cs_n = 1'b1;
                cyc(4);
            end
            set_addr(a);
            if ($urandom_range(0, 1) == 1) do_write(8'($urandom));
            do_read("rd_rand");
        end
        check_all_regs("rand_regs");

`ifdef RTC_RESP_TIMEKEEP_EN
        tick_case(8'h23, 8'h59, 8'h59);
        check("roll_sec", dut.regs_q[0], 8'h00);
        check("roll_min", dut.regs_q[1], 8'h00);
        check("roll_hour", dut.regs_q[2], 8'h00);
        for (int it = 0; it < 4; it++) begin
            tick_case(int2bcd($urandom_range(0, 23)), int2bcd($urandom_range(0, 59)),
                      int2bcd($urandom_range(55, 59)));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
